// File: rtl/rl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rl_seq
//  Purpose  : Multi-cycle rotate-left sequencer for the 4-bit ALU datapath.
//             Accepts an operand, a rotate count and an opcode under a
//             start/done handshake, rotates one bit position per clock and
//             holds the result on registered outputs.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro:
//    RL_CARRY_EN  - when defined, the rotate runs through the carry as a
//                   WIDTH+1-bit ring; cout is loaded from cin at accept.
//                   When undefined, a plain WIDTH-bit rotate is performed,
//                   cin is ignored and cout is tied to 0.
// ----------------------------------------------------------------------------
//  Parameters:
//    WIDTH  operand/result width (>= 2)
//    CNT_W  width of the rotate-count input
//    OPC    opcode value on s that selects this unit
//  Ports:
//    clk    in   1      rising-edge clock
//    Reset  in   1      asynchronous active-low reset
//    start  in   1      request strobe, sampled on the rising edge
//    s      in   4      ALU opcode; request accepted only when s == OPC
//    q      in   WIDTH  operand
//    cnt    in   CNT_W  rotate amount (no modulo-WIDTH folding)
//    cin    in   1      carry in (carry feature only)
//    r      out  WIDTH  result register
//    cout   out  1      carry register (0 without the carry feature)
//    busy   out  1      high while rotating
//    done   out  1      one-cycle completion pulse
// ============================================================================
module rl_seq #(
    parameter int         WIDTH = 4,
    parameter int         CNT_W = 2,
    parameter logic [3:0] OPC   = 4'h5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] q,
    input  logic [CNT_W-1:0] cnt,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_cout;

    // A request is honoured only outside ROT and only for our opcode.
    logic w_accept;
    assign w_accept = start && (s == OPC) && (r_state != S_ROT);

`ifndef RL_CARRY_EN
    // cin has no function in the plain-rotate build.
    logic w_unused_cin;
    assign w_unused_cin = cin;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_count <= c_cnt_zero;
            r_cout  <= 1'b0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r       <= q;
                        r_count <= cnt;
`ifdef RL_CARRY_EN
                        r_cout  <= cin;
`endif
                        // A zero count completes immediately without rotating.
                        if (cnt != c_cnt_zero) begin
                            r_state <= S_ROT;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        // r and cout hold their last values while idle.
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end

                S_ROT: begin
`ifdef RL_CARRY_EN
                    // {r, cout} behaves as one WIDTH+1-bit left-rotating ring.
                    r      <= {r[WIDTH-2:0], r_cout};
                    r_cout <= r[WIDTH-1];
`else
                    r      <= {r[WIDTH-2:0], r[WIDTH-1]};
`endif
                    r_count <= r_count - c_cnt_one;
                    // The counter reaching zero on this edge ends the operation.
                    if (r_count == c_cnt_one) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state <= S_ROT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RL_CARRY_EN
    assign cout = r_cout;
`else
    assign cout = 1'b0;
    // The carry register stays at its reset value in this build.
    logic w_unused_cout;
    assign w_unused_cout = r_cout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rl_seq
//  Purpose  : Self-checking bench for rl_seq. Directed cases followed by
//             randomized operations, compared against a ring-rotation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rl_seq;

    localparam int         c_w   = 4;
    localparam logic [3:0] c_opc = 4'h5;

    logic           clk;
    logic           Reset;
    logic           start;
    logic [3:0]     s;
    logic [c_w-1:0] q;
    logic [1:0]     cnt;
    logic           cin;
    logic [c_w-1:0] r;
    logic           cout;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    rl_seq #(.WIDTH(c_w), .CNT_W(2), .OPC(c_opc)) dut (
        .clk   (clk),
        .Reset (Reset),
        .start (start),
        .s     (s),
        .q     (q),
        .cnt   (cnt),
        .cin   (cin),
        .r     (r),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {r, cout} after k single-bit left rotations of operand qv.
    function automatic logic [4:0] model(input logic [3:0] qv, input logic c, input int k);
        int v;
`ifdef RL_CARRY_EN
        v = {27'd0, qv, c};
        v = ((v << k) | (v >> (5 - k))) & 31;
        return v[4:0];
`else
        v = {28'd0, qv};
        v = ((v << k) | (v >> (4 - k))) & 15;
        return {v[3:0], 1'b0};
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] qv, input logic [1:0] cv, input logic cinv);
        start = 1'b1;
        s     = c_opc;
        q     = qv;
        cnt   = cv;
        cin   = cinv;
    endtask

    // Walks from the accepting edge to the DONE cycle, checking every step.
    // With noisy set, garbage requests are driven throughout ROT.
    task automatic follow(input logic [3:0] qv, input logic [1:0] cv,
                          input logic cinv, input bit noisy);
        logic [4:0] e;
        @(posedge clk); #1;
        start = 1'b0;
        e = model(qv, cinv, 0);
        chk("acc_r",    8'(r),    8'(e[4:1]));
        chk("acc_cout", 8'(cout), 8'(e[0]));
        chk("acc_busy", 8'(busy), 8'(cv != 0));
        chk("acc_done", 8'(done), 8'(cv == 0));
        for (int k = 1; k <= int'(cv); k++) begin
            if (noisy) begin
                start = 1'b1;
                s     = ($urandom % 2 == 0) ? c_opc : 4'($urandom);
                q     = 4'($urandom);
                cnt   = 2'($urandom);
                cin   = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            e = model(qv, cinv, k);
            chk("rot_r",    8'(r),    8'(e[4:1]));
            chk("rot_cout", 8'(cout), 8'(e[0]));
            chk("rot_busy", 8'(busy), 8'(k < int'(cv)));
            chk("rot_done", 8'(done), 8'(k == int'(cv)));
        end
    endtask

    // One idle cycle: done must fall and the result must hold.
    task automatic idle_chk(input logic [3:0] rv, input logic cv);
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 8'(done), 8'd0);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_r",    8'(r),    8'(rv));
        chk("idle_cout", 8'(cout), 8'(cv));
    endtask

    initial begin
        logic [4:0] e;
        logic [3:0] qv;
        logic [1:0] cv;
        logic       cinv;
        Reset = 1'b0;
        start = 1'b0;
        s     = 4'h0;
        q     = '0;
        cnt   = '0;
        cin   = 1'b0;
        #12;
        chk("rst_r",    8'(r),    8'd0);
        chk("rst_cout", 8'(cout), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        Reset = 1'b1;
        @(posedge clk); #1;

        // cnt=1
        issue(4'b1001, 2'd1, 1'b0);
        follow(4'b1001, 2'd1, 1'b0, 1'b0);
        e = model(4'b1001, 1'b0, 1);
        idle_chk(e[4:1], e[0]);

        // cnt=3 walking one
        issue(4'b0001, 2'd3, 1'b0);
        follow(4'b0001, 2'd3, 1'b0, 1'b0);
        e = model(4'b0001, 1'b0, 3);
        idle_chk(e[4:1], e[0]);

        // cnt=0 completes immediately
        issue(4'b1010, 2'd0, 1'b0);
        follow(4'b1010, 2'd0, 1'b0, 1'b0);
        idle_chk(4'b1010, model(4'b1010, 1'b0, 0) & 5'd1);

        // wrong opcode is ignored
        start = 1'b1; s = 4'h4; q = 4'b0101; cnt = 2'd2;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_r",    8'(r),    8'(4'b1010));
        chk("ign_busy", 8'(busy), 8'd0);
        chk("ign_done", 8'(done), 8'd0);

        // requests during ROT ignored, then back-to-back from DONE
        issue(4'b0011, 2'd3, 1'b1);
        follow(4'b0011, 2'd3, 1'b1, 1'b1);
        issue(4'b0110, 2'd2, 1'b0);
        follow(4'b0110, 2'd2, 1'b0, 1'b0);
        e = model(4'b0110, 1'b0, 2);
        idle_chk(e[4:1], e[0]);

        // carry ring directed cases (plain rotate in the default build)
        issue(4'b1000, 2'd1, 1'b0);
        follow(4'b1000, 2'd1, 1'b0, 1'b0);
        issue(4'b0000, 2'd2, 1'b1);
        follow(4'b0000, 2'd2, 1'b1, 1'b0);
        e = model(4'b0000, 1'b1, 2);
        idle_chk(e[4:1], e[0]);

        // asynchronous reset mid-ROT
        issue(4'b0111, 2'd3, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        Reset = 1'b0;
        #1;
        chk("arst_r",    8'(r),    8'd0);
        chk("arst_cout", 8'(cout), 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_done", 8'(done), 8'd0);
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("arst_nodone", 8'(done), 8'd0);
            chk("arst_nobusy", 8'(busy), 8'd0);
        end

        // randomized operations, some noisy, some back-to-back
        for (int n = 0; n < 30; n++) begin
            qv   = 4'($urandom);
            cv   = 2'($urandom);
            cinv = 1'($urandom);
            issue(qv, cv, cinv);
            follow(qv, cv, cinv, 1'($urandom));
            if ($urandom % 3 == 0) begin
                e = model(qv, cinv, int'(cv));
                idle_chk(e[4:1], e[0]);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("end_done", 8'(done), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
